// File: rtl/div_pkg.sv
// Shared defaults and FSM state encoding for the radix-2 restoring divider.
package div_pkg;

    localparam int DVD_W_DEF = 32;
    localparam int DVS_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational. Backpressure: none (pure function).
// The remainder entering a step is always < divisor, so the shifted value never exceeds DVS_W+1 bits.
module div_step
    import div_pkg::*;
#(
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic [DVS_W:0]   rem_in,
    input  logic [DVS_W-1:0] divisor,
    input  logic             bit_in,
    output logic [DVS_W:0]   rem_out,
    output logic             q_bit
);

    logic [DVS_W+1:0] shifted;
    logic [DVS_W+1:0] dvs_ext;

    assign shifted = {rem_in, bit_in};
    assign dvs_ext = {2'b00, divisor};

    always_comb begin
        q_bit   = (shifted >= dvs_ext);
        rem_out = q_bit ? (DVS_W+1)'(shifted - dvs_ext) : (DVS_W+1)'(shifted);
    end

endmodule

// File: rtl/radix2_divider.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle, MSB first.
// Latency: DVD_W cycles from acceptance (1 cycle for divisor 0 when DIV_ZERO_BYPASS_EN is defined).
// Backpressure: single operation in flight; result held in DONE until out_ready, in_ready only in IDLE.
module radix2_divider
    import div_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(DVD_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DVD_W - 1);

    div_state_t       state;
    logic [CNT_W-1:0] step_cnt;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [DVD_W-1:0] work;
    logic [DVS_W-1:0] dvs;
    logic [DVS_W:0]   prem;
    logic [DVS_W-1:0] dvd_lo;
    logic             dz_op;

    logic [DVS_W:0]   nxt_rem;
    logic             q_bit;

    div_step #(.DVS_W(DVS_W)) u_step (
        .rem_in  (prem),
        .divisor (dvs),
        .bit_in  (work[DVD_W-1]),
        .rem_out (nxt_rem),
        .q_bit   (q_bit)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            step_cnt    <= '0;
            work        <= '0;
            dvs         <= '0;
            prem        <= '0;
            dvd_lo      <= '0;
            dz_op       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= dividend;
                        dvs      <= divisor;
                        prem     <= '0;
                        step_cnt <= '0;
                        dvd_lo   <= dividend[DVS_W-1:0];
                        dz_op    <= (divisor == '0);
`ifdef DIV_ZERO_BYPASS_EN
                        if (divisor == '0) begin
                            state       <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend[DVS_W-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    work     <= {work[DVD_W-2:0], q_bit};
                    prem     <= nxt_rem;
                    step_cnt <= step_cnt + 1'b1;
                    if (step_cnt == LAST_STEP) begin
                        state <= DONE;
                        // Divide-by-zero results are forced rather than taken from the datapath.
                        if (dz_op) begin
                            quotient    <= '1;
                            remainder   <= dvd_lo;
                            div_by_zero <= 1'b1;
                        end else begin
                            quotient    <= {work[DVD_W-2:0], q_bit};
                            remainder   <= nxt_rem[DVS_W-1:0];
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/radix2_divider.md
RADIX2_DIVIDER -- requirements
Module: radix2_divider

Interface
REQ-001 SHALL have parameters: DVD_W, default 32, dividend/quotient width; DVS_W, default 16, divisor/remainder width.
REQ-002 SHALL have one clock and an asynchronous, active-high reset; ports named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  dividend/divisor offered.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 dividend  input  DVD_W  numerator, unsigned (matches the 32-bit multiplier product).
REQ-008 divisor  input  DVS_W  denominator, unsigned (matches the 16-bit multiplier operands).
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 quotient  output  DVD_W  floor(dividend/divisor).
REQ-012 remainder  output  DVS_W  dividend mod divisor.
REQ-013 div_by_zero  output  1  result produced with divisor == 0.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a transfer occurs on a clock edge with in_valid && in_ready.
REQ-016 On transfer, SHALL latch operands, clear the 17-bit partial remainder, set step count to 0, and go to RUN.
REQ-017 Each RUN edge SHALL perform one restoring step, MSB first: shift in the next dividend bit; if the partial remainder >= divisor, subtract it and set the quotient bit to 1, else set it to 0.
REQ-018 After step DVD_W-1 (32nd RUN edge), SHALL go to DONE with out_valid = 1; latency is DVD_W cycles from the accepting edge.
REQ-019 The partial remainder SHALL be DVS_W+1 bits wide internally; the remainder output SHALL be its low DVS_W bits.
REQ-020 In DONE, quotient, remainder, and div_by_zero SHALL stay stable until out_valid && out_ready, then go to IDLE.
REQ-021 in_valid during RUN/DONE SHALL be ignored; no operation overlap.
REQ-022 For divisor == 0: quotient = all ones, remainder = dividend[DVS_W-1:0], div_by_zero = 1.
REQ-023 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-024 On rst, SHALL enter IDLE immediately: in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0, step count = 0.
REQ-025 Reset during RUN or DONE SHALL abort the operation; no result is delivered.

Configuration
REQ-026 Macro DIV_ZERO_BYPASS_EN: when defined, divisor == 0 SHALL go from IDLE straight to DONE one edge after acceptance (latency 1).
REQ-027 When the macro is undefined, divisor == 0 SHALL run the full DVD_W steps. Output values SHALL be forced per REQ-022 in both cases.

Structure
REQ-028 Package div_pkg SHALL hold the DVD_W/DVS_W defaults and the FSM state enum typedef.
REQ-029 One combinational sub-module, div_step, SHALL compute a single restoring step: partial remainder, divisor, and incoming bit in; next remainder and quotient bit out.

Verification
REQ-030 100 / 7 -> quotient 14, remainder 2, div_by_zero 0, out_valid exactly 32 cycles after acceptance.
REQ-031 Round trip with the multiplier: 0xFFFE0001 / 0xFFFF -> quotient 0x0000FFFF, remainder 0.
REQ-032 0x12345678 / 0 -> quotient 0xFFFFFFFF, remainder 0x5678, div_by_zero 1; latency 1 with DIV_ZERO_BYPASS_EN, 32 without.
REQ-033 Backpressure: hold out_ready = 0 for 10 cycles after out_valid -> outputs stable, in_ready = 0, new in_valid ignored; result consumed on the first out_ready = 1 edge, then in_ready = 1.
REQ-034 Assert rst at RUN step 15 -> next cycle: in_ready = 1, out_valid = 0, outputs 0; a following 9 / 3 -> quotient 3, remainder 0.
REQ-035 Random sweep of 10,000 operand pairs -> quotient*divisor + remainder == dividend and remainder < divisor for every nonzero divisor.
